// File: rtl/mips_multicycle_control_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, state
// encoding and the datapath mux/ALU select encodings.
package mips_pkg;

    // Instruction opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Controller states, 4-bit binary; 4'd12..4'd15 are unused
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True when the opcode is one the controller knows how to sequence
    function automatic logic is_supported_op(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle datapath and its controller.
// The datapath side (master) supplies opcode and status; the controller
// side (slave) returns the datapath control strobes and its current state.
interface mips_multicycle_control_if;

    // Datapath status into the controller
    logic [5:0] op;
    logic       mem_ready;
    logic       zero;

    // Control strobes back to the datapath
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;

    // Current controller state, for observation/debug
    logic [3:0] state;

    modport master (
        output op, mem_ready, zero,
        input  iord, mem_read, mem_write, ir_write, pc_write, pc_en, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
               illegal_op, state
    );

    modport slave (
        input  op, mem_ready, zero,
        output iord, mem_read, mem_write, ir_write, pc_write, pc_en, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
               illegal_op, state
    );

endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main controller. A single state register drives a Moore
// output decode; only the FETCH-state instruction/PC loads follow
// mem_ready so a slow instruction fetch does not advance the PC.
// While reset is high every write-type strobe is held low.
module mips_multicycle_control
    import mips_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    mips_multicycle_control_if.slave        bus
);

    state_e     r_state;
    state_e     w_next_state;

    // Raw Moore decode of the state register
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_branch;
    logic [1:0] w_pc_src;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_illegal_op;

    // Strobes after reset masking
    logic       w_ir_write_g;
    logic       w_pc_write_g;
    logic       w_pc_en_g;
    logic       w_mem_write_g;
    logic       w_reg_write_g;
    logic       w_illegal_op_g;

    // State register; reset forces FETCH immediately, independent of clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection; any unused encoding falls back to FETCH
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    w_next_state = S_DECODE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXEC;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = S_JUMP;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                // The IR is stable here, so op still names LW or SW
                if (bus.op == OP_LW) begin
                    w_next_state = S_MEMRD;
                end else if (bus.op == OP_SW) begin
                    w_next_state = S_MEMWR;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_MEMRD: begin
                if (bus.mem_ready) begin
                    w_next_state = S_MEMWB;
                end else begin
                    w_next_state = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (bus.mem_ready) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_MEMWR;
                end
            end
            S_EXEC:   w_next_state = S_ALUWB;
            S_ADDIEX: w_next_state = S_ADDIWB;
            S_MEMWB,
            S_ALUWB,
            S_ADDIWB,
            S_BRANCH,
            S_JUMP:   w_next_state = S_FETCH;
            default:  w_next_state = S_FETCH;
        endcase
    end

    // Moore output decode; everything not named in a state stays 0
    always_comb begin
        w_iord       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_pc_src     = PCSRC_ALU;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = SRCB_REG;
        w_alu_op     = ALUOP_ADD;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_illegal_op = 1'b0;
        case (r_state)
            S_FETCH: begin
                // PC+4 computed every fetch cycle; loads wait for memory
                w_mem_read  = 1'b1;
                w_alu_src_b = SRCB_FOUR;
                w_ir_write  = bus.mem_ready;
                w_pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                // Speculative branch target PC + (imm << 2)
                w_alu_src_b  = SRCB_IMM_SH;
                w_illegal_op = ~is_supported_op(bus.op);
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
            end
            S_MEMWB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALUOP_SUB;
                w_pc_src    = PCSRC_ALUOUT;
                w_branch    = 1'b1;
            end
            S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
            end
            S_JUMP: begin
                w_pc_src   = PCSRC_JUMP;
                w_pc_write = 1'b1;
            end
            default: begin
                w_illegal_op = 1'b0;
            end
        endcase
    end

    // Hold every write-type strobe low while reset is asserted
    always_comb begin
        w_ir_write_g   = 1'b0;
        w_pc_write_g   = 1'b0;
        w_pc_en_g      = 1'b0;
        w_mem_write_g  = 1'b0;
        w_reg_write_g  = 1'b0;
        w_illegal_op_g = 1'b0;
        if (reset) begin
            w_ir_write_g   = 1'b0;
            w_pc_write_g   = 1'b0;
            w_pc_en_g      = 1'b0;
            w_mem_write_g  = 1'b0;
            w_reg_write_g  = 1'b0;
            w_illegal_op_g = 1'b0;
        end else begin
            w_ir_write_g   = w_ir_write;
            w_pc_write_g   = w_pc_write;
            w_pc_en_g      = w_pc_write | (w_branch & bus.zero);
            w_mem_write_g  = w_mem_write;
            w_reg_write_g  = w_reg_write;
            w_illegal_op_g = w_illegal_op;
        end
    end

    assign bus.iord       = w_iord;
    assign bus.mem_read   = w_mem_read;
    assign bus.mem_write  = w_mem_write_g;
    assign bus.ir_write   = w_ir_write_g;
    assign bus.pc_write   = w_pc_write_g;
    assign bus.pc_en      = w_pc_en_g;
    assign bus.pc_src     = w_pc_src;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.alu_op     = w_alu_op;
    assign bus.reg_dst    = w_reg_dst;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.reg_write  = w_reg_write_g;
    assign bus.illegal_op = w_illegal_op_g;
    assign bus.state      = r_state;

endmodule

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 Parameters: none; opcode encodings are shared constants (REQ-030).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears state immediately, independent of clk.
REQ-004 op  input  6  instruction[31:26] from instruction register.
REQ-005 mem_ready  input  1  memory handshake; high = current access completes this cycle.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 iord  output  1  0=PC, 1=ALUOut as memory address.
REQ-008 mem_read, mem_write  output  1 each  memory access request.
REQ-009 ir_write  output  1  load instruction register.
REQ-010 pc_write  output  1  unconditional PC load.
REQ-011 pc_en  output  1  final PC enable = pc_write | (branch & zero).
REQ-012 pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-013 alu_src_a  output  1  0=PC, 1=register A.
REQ-014 alu_src_b  output  2  00=B, 01=constant 4, 10=sign-extended imm16 (32b), 11=sign-extended imm16 << 2.
REQ-015 alu_op  output  2  00=add, 01=sub, 10=funct-decoded.
REQ-016 reg_dst, mem_to_reg, reg_write  output  1 each  register-file write control.
REQ-017 illegal_op  output  1  one-cycle pulse on unsupported opcode.

Function
REQ-018 Outputs shall be a Moore decode of the state register, except ir_write, pc_write, pc_en in FETCH, which shall be gated by mem_ready; all unlisted outputs 0 in every state.
REQ-019 States and per-state outputs:
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, ir_write=pc_write=mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00.
- MEMRD: mem_read=1, iord=1.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1.
- MEMWR: mem_write=1, iord=1.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch internal=1.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1.
- JUMP: pc_src=10, pc_write=1.
REQ-020 Transitions: FETCH->DECODE when mem_ready, else hold FETCH.
REQ-021 DECODE: LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP, other->FETCH with illegal_op=1 that cycle.
REQ-022 MEMADR: LW->MEMRD, SW->MEMWR; op sampled combinationally from the held IR.
REQ-023 MEMRD->MEMWB and MEMWR->FETCH only when mem_ready; otherwise hold, with mem_read/mem_write held high.
REQ-024 MEMWB, ALUWB, ADDIWB, BRANCH, JUMP->FETCH unconditionally; EXEC->ALUWB; ADDIEX->ADDIWB.
REQ-025 Latency with mem_ready constantly high: R-type 4 cycles, LW 5, SW 4, BEQ 3, ADDI 4, J 3.
REQ-026 pc_en in BRANCH = zero; BEQ not taken leaves PC unchanged.
REQ-027 State encoding 4-bit binary; unused encodings shall return to FETCH on the next edge with all outputs 0.

Reset
REQ-028 Reset asserted: state=FETCH asynchronously; while reset high all write-type outputs (ir_write, pc_write, pc_en, mem_write, reg_write) shall be forced 0, and illegal_op=0.
REQ-029 Reset mid-instruction (any state, incl. stalled MEMRD/MEMWR) aborts it; first cycle after deassertion is FETCH.

Structure
REQ-030 Opcode constants (RTYPE=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010), state encodings, and alu_src_b/alu_op/pc_src encodings in shared package mips_pkg.
REQ-031 Single module: state register plus next-state and output decode; no sub-module.

Verification
REQ-032 LW (op=100011), mem_ready=1: states FETCH,DECODE,MEMADR,MEMRD,MEMWB; alu_src_b=10 in MEMADR; reg_write=1 only in cycle 5.
REQ-033 SW with mem_ready low for 3 cycles in MEMWR -> mem_write high 4 cycles, then FETCH.
REQ-034 BEQ with zero=1 -> pc_en=1, pc_src=01 in cycle 3; zero=0 -> pc_en=0.
REQ-035 op=111111 -> illegal_op pulse in DECODE, next state FETCH, no write strobes.
REQ-036 reset asserted mid-MEMRD between edges -> state FETCH immediately, write strobes 0; resumes fetch after release.
REQ-037 FETCH with mem_ready=0 for 2 cycles -> ir_write=pc_write=0, state held, advance on third cycle.
